// File: rtl/unary_bitstream_gen.sv
// Multi-channel LFSR-driven unary/stochastic bitstream generator with a valid/ready stream port.
// Optional per-channel ones counters are built when UBG_POPCOUNT_EN is defined.
module unary_bitstream_gen #(
  parameter int                LFSR_W     = 13,
  parameter logic [LFSR_W-1:0] TAPS       = 13'h100D,
  parameter int                CHANNELS   = 4,
  parameter int                STREAM_LEN = 8192,
  parameter int                ROT_STEP   = 0,
  localparam int               IDX_W      = (STREAM_LEN > 1) ? $clog2(STREAM_LEN) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [LFSR_W-1:0]            seed_in,
  input  logic [CHANNELS*LFSR_W-1:0]   scalar_in,
  output logic                         busy,
  output logic                         done,
  output logic                         bs_valid,
  input  logic                         bs_ready,
  output logic [CHANNELS-1:0]          bs_out,
`ifdef UBG_POPCOUNT_EN
  output logic [IDX_W-1:0]             bit_idx,
  output logic [CHANNELS*($clog2(STREAM_LEN)+1)-1:0] ones_cnt
`else
  output logic [IDX_W-1:0]             bit_idx
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                            state_q, state_d;
  logic [LFSR_W-1:0]                 lfsr_q;
  logic [LFSR_W-1:0]                 lfsr_next;
  logic [CHANNELS-1:0][LFSR_W-1:0]   scalar_q;
  logic [IDX_W-1:0]                  idx_q;
  logic [CHANNELS-1:0]               raw_bits;
  logic                              accept;
  logic                              xfer;
  logic                              last_bit;

  assign accept    = (state_q == S_IDLE) && start;
  assign xfer      = (state_q == S_RUN) && bs_ready;
  assign last_bit  = (idx_q == IDX_W'(STREAM_LEN - 1));
  assign lfsr_next = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAPS)};
  assign bit_idx   = idx_q;

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (bs_ready && last_bit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: everything derives from registered state, never from the handshake inputs.
  always_comb begin
    busy     = (state_q == S_RUN);
    bs_valid = (state_q == S_RUN);
    done     = (state_q == S_DONE);
    bs_out   = (state_q == S_RUN) ? raw_bits : '0;
  end

  // NOTE: the scalar bank is reset too; it is small and a clean zero keeps bs_out defined after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q   <= LFSR_W'(1);
      scalar_q <= '0;
      idx_q    <= '0;
    end else if (accept) begin
      lfsr_q   <= (seed_in == '0) ? LFSR_W'(1) : seed_in;
      scalar_q <= scalar_in;
      idx_q    <= '0;
    end else if (xfer) begin
      lfsr_q   <= lfsr_next;
      idx_q    <= idx_q + IDX_W'(1);
    end
  end

  // Channel c compares against the shared LFSR rotated left by a fixed per-channel amount.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    localparam int ROT = (c * ROT_STEP) % LFSR_W;
    logic [2*LFSR_W-1:0] dbl;
    logic [LFSR_W-1:0]   rot_sample;
    assign dbl         = {lfsr_q, lfsr_q};
    assign rot_sample  = dbl[2*LFSR_W-1-ROT -: LFSR_W];
    assign raw_bits[c] = (scalar_q[c] > rot_sample);
  end

`ifdef UBG_POPCOUNT_EN
  localparam int CNT_W = $clog2(STREAM_LEN) + 1;
  logic [CHANNELS-1:0][CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n || accept) begin
      cnt_q <= '0;
    end else if (xfer) begin
      for (int c = 0; c < CHANNELS; c++) cnt_q[c] <= cnt_q[c] + CNT_W'(raw_bits[c]);
    end
  end

  assign ones_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_unary_bitstream_gen.sv
// Randomized self-checking bench for unary_bitstream_gen against an arithmetic stream model.
// Two instances share all inputs: the default build and one with channel rotation enabled.
module tb_unary_bitstream_gen;

  localparam int W    = 13;
  localparam int CH   = 4;
  localparam int LEN  = 8192;
  localparam int MASK = 8191;
  localparam int TAPS = 'h100D;
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;
  localparam int CNT_W = 14;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [W-1:0]    seed_in = '0;
  logic [CH*W-1:0] scalar_in = '0;
  logic            bs_ready = 1'b0;
  logic            busy, done, bs_valid;
  logic [CH-1:0]   bs_out;
  logic [W-1:0]    bit_idx;
  logic            busy_r, done_r, bs_valid_r;
  logic [CH-1:0]   bs_out_rot;
  logic [W-1:0]    bit_idx_r;
`ifdef UBG_POPCOUNT_EN
  logic [CH*CNT_W-1:0] ones_cnt, ones_cnt_r;
`endif

  always #5 clk = ~clk;

  unary_bitstream_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed_in(seed_in), .scalar_in(scalar_in),
    .busy(busy), .done(done), .bs_valid(bs_valid), .bs_ready(bs_ready), .bs_out(bs_out),
`ifdef UBG_POPCOUNT_EN
    .ones_cnt(ones_cnt),
`endif
    .bit_idx(bit_idx)
  );

  unary_bitstream_gen #(.ROT_STEP(1)) dut_rot (
    .clk(clk), .rst_n(rst_n), .start(start), .seed_in(seed_in), .scalar_in(scalar_in),
    .busy(busy_r), .done(done_r), .bs_valid(bs_valid_r), .bs_ready(bs_ready), .bs_out(bs_out_rot),
`ifdef UBG_POPCOUNT_EN
    .ones_cnt(ones_cnt_r),
`endif
    .bit_idx(bit_idx_r)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: what the generator has produced so far, in plain integers.
  int m_state = M_IDLE;
  int m_lfsr  = 1;
  int m_idx   = 0;
  int m_scal[CH];
  int m_ones[CH];

  logic [CH-1:0] last_stream[$];
  logic [CH-1:0] ref_stream[$];

  function automatic int lfsr_step(input int x);
    int fb = $countones(x & TAPS) & 1;
    return ((x << 1) | fb) & MASK;
  endfunction

  function automatic int rotl(input int x, input int r);
    return ((x << r) | (x >> (W - r))) & MASK;
  endfunction

  function automatic logic [CH-1:0] model_bits(input int rot);
    logic [CH-1:0] b = '0;
    for (int c = 0; c < CH; c++)
      b[c] = (m_state == M_RUN) && (m_scal[c] > rotl(m_lfsr, (c * rot) % W));
    return b;
  endfunction

  function automatic int count_ones(input int ch);
    int n = 0;
    foreach (last_stream[i]) n += int'(last_stream[i][ch]);
    return n;
  endfunction

  task automatic model_edge(input logic st, input logic rd);
    logic [CH-1:0] b = model_bits(0);
    if (!rst_n) begin
      m_state = M_IDLE; m_lfsr = 1; m_idx = 0;
      for (int c = 0; c < CH; c++) begin m_scal[c] = 0; m_ones[c] = 0; end
    end else if (m_state == M_IDLE) begin
      if (st) begin
        m_lfsr = (seed_in == '0) ? 1 : int'(seed_in);
        for (int c = 0; c < CH; c++) begin m_scal[c] = int'(scalar_in[c*W +: W]); m_ones[c] = 0; end
        m_idx = 0; m_state = M_RUN;
      end
    end else if (m_state == M_RUN) begin
      if (rd) begin
        for (int c = 0; c < CH; c++) m_ones[c] += int'(b[c]);
        if (m_idx == LEN - 1) m_state = M_DONE;
        m_lfsr = lfsr_step(m_lfsr);
        m_idx  = (m_idx + 1) % LEN;
      end
    end else begin
      m_state = M_IDLE;
    end
  endtask

  // One clock: drive at the falling edge, advance the model at the rising edge, settle 1 ns.
  task automatic step(input logic st, input logic rd);
    @(negedge clk);
    start = st; bs_ready = rd;
    @(posedge clk);
    model_edge(st, rd);
    #1;
  endtask

  task automatic set_scalars(input int s0, input int s1, input int s2, input int s3);
    scalar_in = {13'(s3), 13'(s2), 13'(s1), 13'(s0)};
  endtask

  // Streams until the model returns to idle, comparing every observable output each cycle.
  task automatic run_stream(input string name, input int ready_pct, input int hold_at,
                            input int hold_len, input int abort_at);
    int held = 0;
    int cyc  = 0;
    logic rd;
    logic [23:0] got, want;
    last_stream.delete();
    while (m_state != M_IDLE && cyc < 40000) begin
      got  = {busy, done, bs_valid, bs_out, bs_out_rot, bit_idx};
      want = {m_state == M_RUN, m_state == M_DONE, m_state == M_RUN,
              model_bits(0), model_bits(1), 13'(m_idx)};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL %s cyc%0d: got busy/done/valid/out/rot/idx=%h want %h", name, cyc, got, want);
      end
`ifdef UBG_POPCOUNT_EN
      for (int c = 0; c < CH; c++) begin
        n_cmp++;
        if (int'(ones_cnt[c*CNT_W +: CNT_W]) != m_ones[c]) begin
          n_bad++;
          $display("FAIL %s ones_cnt[%0d]: got %0d want %0d", name, c, ones_cnt[c*CNT_W +: CNT_W], m_ones[c]);
        end
      end
`endif
      if (abort_at >= 0 && m_state == M_RUN && m_idx == abort_at) begin
        rst_n = 1'b0;
        step(1'b0, 1'b1);
        rst_n = 1'b1;
        continue;
      end
      if (m_state == M_RUN && m_idx == hold_at && held < hold_len) begin
        rd = 1'b0; held++;
      end else begin
        rd = ($urandom_range(99) < ready_pct);
      end
      if (m_state == M_RUN && rd) last_stream.push_back(bs_out);
      step(1'b0, rd);
      cyc++;
    end
    n_cmp++;
    if (m_state != M_IDLE || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL %s end: busy=%b done=%b after %0d cycles, want idle", name, busy, done, cyc);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    rst_n = 1'b1;
    n_cmp++; if (bs_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bs_valid); end
    n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0)     begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (bs_out !== 4'h0)   begin n_bad++; $display("FAIL reset_out: got %h want 0", bs_out); end
    n_cmp++; if (bit_idx !== 13'd0) begin n_bad++; $display("FAIL reset_idx: got %0d want 0", bit_idx); end
  endtask

  task automatic test_zero_stream;
    seed_in = 13'd1;
    set_scalars(0, 0, 0, 0);
    step(1'b1, 1'b1);
    run_stream("zero_stream", 100, -1, 0, -1);
    n_cmp++;
    if (last_stream.size() != LEN) begin
      n_bad++; $display("FAIL zero_len: got %0d bits want %0d", last_stream.size(), LEN);
    end
    for (int c = 0; c < CH; c++) begin
      n_cmp++;
      if (count_ones(c) != 0) begin n_bad++; $display("FAIL zero_ones[%0d]: got %0d want 0", c, count_ones(c)); end
    end
  endtask

  task automatic test_ones_count;
    seed_in = 13'd1;
    set_scalars(4096, 8191, 0, 0);
    step(1'b1, 1'b1);
    run_stream("ones_count", 100, -1, 0, -1);
    n_cmp++; if (count_ones(0) != 4096) begin n_bad++; $display("FAIL ones_ch0: got %0d want 4096", count_ones(0)); end
    n_cmp++; if (count_ones(1) != 8191) begin n_bad++; $display("FAIL ones_ch1: got %0d want 8191", count_ones(1)); end
`ifdef UBG_POPCOUNT_EN
    n_cmp++; if (ones_cnt[0 +: CNT_W] != 14'd4096) begin n_bad++; $display("FAIL cnt_ch0: got %0d want 4096", ones_cnt[0 +: CNT_W]); end
    n_cmp++; if (ones_cnt[CNT_W +: CNT_W] != 14'd8191) begin n_bad++; $display("FAIL cnt_ch1: got %0d want 8191", ones_cnt[CNT_W +: CNT_W]); end
`endif
    ref_stream = last_stream;
  endtask

  task automatic test_seed_zero;
    int diffs = 0;
    seed_in = 13'd0;
    set_scalars(4096, 8191, 0, 0);
    step(1'b1, 1'b1);
    run_stream("seed_zero", 60, -1, 0, -1);
    if (last_stream.size() != ref_stream.size()) diffs = LEN;
    else foreach (last_stream[i]) if (last_stream[i] !== ref_stream[i]) diffs++;
    n_cmp++;
    if (diffs != 0) begin n_bad++; $display("FAIL seed_zero_stream: got %0d differing bits want 0", diffs); end
  endtask

  task automatic test_stall;
    logic [CH-1:0] nostall[$];
    int diffs = 0;
    int seed = $urandom_range(1, MASK);
    int s0 = $urandom_range(0, MASK), s1 = $urandom_range(0, MASK);
    int s2 = $urandom_range(0, MASK), s3 = $urandom_range(0, MASK);
    seed_in = 13'(seed);
    set_scalars(s0, s1, s2, s3);
    step(1'b1, 1'b1);
    run_stream("nostall", 100, -1, 0, 300);
    nostall = last_stream;
    step(1'b1, 1'b1);
    run_stream("stall", 80, 100, 5, 300);
    if (last_stream.size() != nostall.size()) diffs = 300;
    else foreach (last_stream[i]) if (last_stream[i] !== nostall[i]) diffs++;
    n_cmp++;
    if (diffs != 0 || nostall.size() != 300) begin
      n_bad++; $display("FAIL stall_stream: got %0d diffs, %0d bits want 0 diffs, 300 bits", diffs, nostall.size());
    end
  endtask

  task automatic test_restart;
    int cyc = 0;
    seed_in = 13'($urandom_range(1, MASK));
    set_scalars($urandom_range(0, MASK), $urandom_range(0, MASK), $urandom_range(0, MASK), $urandom_range(0, MASK));
    step(1'b1, 1'b1);
    while (m_idx < 200 && cyc < 1000) begin
      n_cmp++;
      if (bs_out !== model_bits(0) || bit_idx !== 13'(m_idx)) begin
        n_bad++; $display("FAIL restart_bits idx%0d: got out=%h idx=%0d want out=%h", m_idx, bs_out, bit_idx, model_bits(0));
      end
      if (m_idx == 50) begin
        seed_in = ~seed_in;
        set_scalars($urandom_range(0, MASK), $urandom_range(0, MASK), $urandom_range(0, MASK), $urandom_range(0, MASK));
        step(1'b1, 1'b1);
      end else begin
        step(1'b0, 1'b1);
      end
      cyc++;
    end
    rst_n = 1'b0;
    step(1'b0, 1'b1);
    rst_n = 1'b1;
    n_cmp++;
    if (bs_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL abort_outputs: got valid=%b busy=%b done=%b want 0 0 0", bs_valid, busy, done);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1);
      n_cmp++;
      if (done !== 1'b0) begin n_bad++; $display("FAIL abort_no_done: got %b want 0", done); end
    end
    seed_in = 13'($urandom_range(1, MASK));
    step(1'b1, 1'b1);
    n_cmp++;
    if (bit_idx !== 13'd0 || bs_valid !== 1'b1) begin
      n_bad++; $display("FAIL restart_start: got idx=%0d valid=%b want 0 1", bit_idx, bs_valid);
    end
    run_stream("restart_stream", 90, -1, 0, -1);
  endtask

  task automatic test_rotation;
    seed_in = 13'd1;
    set_scalars(4096, 4096, 4096, 4096);
    step(1'b1, 1'b1);
    // Bit 0: samples 1, 2, 4, 8 are all below 4096.
    n_cmp++;
    if (bs_out_rot !== 4'b1111) begin n_bad++; $display("FAIL rot_bit0: got %b want 1111", bs_out_rot); end
    run_stream("rotation", 100, -1, 0, 200);
  endtask

  initial begin
    test_reset();
    test_zero_stream();
    test_ones_count();
    test_seed_zero();
    test_stall();
    test_restart();
    test_rotation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
